// File: rtl/riscv_clint_pkg.sv
// Register map, reset constants and address decode for the CLINT.
// Decode is purely combinational; no state lives here.
// Decoded selects carry the hart index so the top can fan writes out.
package riscv_clint_pkg;

    localparam logic [15:0] CLINT_OFF_MSIP     = 16'h0000;
    localparam logic [15:0] CLINT_OFF_MTIMECMP = 16'h4000;
    localparam logic [15:0] CLINT_OFF_PRESCALE = 16'hBFF0;
    localparam logic [15:0] CLINT_OFF_MTIME    = 16'hBFF8;

    // All-ones compare value keeps the timer interrupt quiet after reset.
    localparam logic [63:0] CLINT_MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_PRESCALE,
        SEL_MTIME_LO,
        SEL_MTIME_HI
    } clint_sel_e;

    typedef struct packed {
        clint_sel_e  sel;
        logic [3:0]  hart;
    } clint_dec_t;

    // Decode a word index (byte address bits [15:2]) into a register select.
    // Hart-indexed regions beyond num_harts decode to SEL_NONE.
    function automatic clint_dec_t clint_decode(input logic [13:0] idx, input int num_harts);
        clint_dec_t d;
        d.sel  = SEL_NONE;
        d.hart = 4'd0;
        if (idx[13:4] == CLINT_OFF_MSIP[15:6]) begin
            if (int'(idx[3:0]) < num_harts) begin
                d.sel  = SEL_MSIP;
                d.hart = idx[3:0];
            end
        end else if (idx[13:5] == CLINT_OFF_MTIMECMP[15:7]) begin
            if (int'(idx[4:1]) < num_harts) begin
                d.sel  = idx[0] ? SEL_CMP_HI : SEL_CMP_LO;
                d.hart = idx[4:1];
            end
        end else if (idx == CLINT_OFF_PRESCALE[15:2]) begin
            d.sel = SEL_PRESCALE;
        end else if (idx == CLINT_OFF_MTIME[15:2]) begin
            d.sel = SEL_MTIME_LO;
        end else if (idx == CLINT_OFF_MTIME[15:2] + 14'd1) begin
            d.sel = SEL_MTIME_HI;
        end
        return d;
    endfunction

endpackage

// File: rtl/riscv_pkg.sv
// Shared definitions used across the RISC-V subsystem.
// Holds the bus word type common to every memory-mapped slave.
// No logic lives here.
package riscv_pkg;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/mem_if.sv
// System memory bus: single-beat request with registered read data.
// Read data is valid one cycle after a read request.
// Slaves signal backpressure through ready.
interface mem_if;
    import riscv_pkg::*;

    word_t addr;
    logic  valid;
    logic  w_en;
    word_t w_data;
    word_t r_data;
    logic  ready;

    modport master (output addr, output valid, output w_en, output w_data,
                    input r_data, input ready);
    modport slave  (input addr, input valid, input w_en, input w_data,
                    output r_data, output ready);
endinterface

// File: rtl/riscv_clint_prescaler.sv
// Prescale divider for mtime: tick once every prescale+1 cycles.
// Combinational tick from the current count; counter updates on the edge.
// No backpressure; clr restarts the count from 0.
module riscv_clint_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clr,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre;

    assign tick = (pre == prescale);

    // Count up to prescale, wrapping on a tick; a clear restarts the period.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pre <= '0;
        end else if (clr || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/riscv_clint.sv
// Core-local interruptor: shared prescaled mtime, per-hart mtimecmp/msip, bus slave.
// Reads return 1 cycle after the request; writes land on the accepting edge; mtip lags 2 edges.
// Never stalls (ready tied high). Software interrupts only with RISCV_CLINT_MSIP_EN defined.
module riscv_clint
    import riscv_pkg::*;
    import riscv_clint_pkg::*;
#(
    parameter int NUM_HARTS  = 1,
    parameter int PRESCALE_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic [NUM_HARTS-1:0] o_mtip,
    output logic [NUM_HARTS-1:0] o_msip,
    output logic [31:0]          o_time,
    output logic [31:0]          o_timeh,
    mem_if.slave                 if_mem
);

    clint_dec_t            dec;
    logic                  wr_vld;
    logic                  rd_vld;
    logic                  tick;
    logic                  pre_clr;
    logic [63:0]           mtime;
    logic [31:0]           mtime_hi_shadow;
    logic [PRESCALE_W-1:0] prescale;
    logic [63:0]           mtimecmp [NUM_HARTS];
    word_t                 rd_dat;
    logic                  unused_addr_bits;

    assign dec     = clint_decode(if_mem.addr[15:2], NUM_HARTS);
    assign wr_vld  = if_mem.valid &&  if_mem.w_en;
    assign rd_vld  = if_mem.valid && !if_mem.w_en;
    assign if_mem.ready = 1'b1;
    assign o_time  = mtime[31:0];
    assign o_timeh = mtime[63:32];
    assign unused_addr_bits = ^{if_mem.addr[31:16], if_mem.addr[1:0]};

    // Any mtime write or prescale write restarts the divider period.
    assign pre_clr = wr_vld && (dec.sel == SEL_PRESCALE ||
                                dec.sel == SEL_MTIME_LO ||
                                dec.sel == SEL_MTIME_HI);

    riscv_clint_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .prescale (prescale),
        .clr      (pre_clr),
        .tick     (tick)
    );

    // Prescale register; only the low PRESCALE_W bits are stored.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prescale <= '0;
        end else if (wr_vld && dec.sel == SEL_PRESCALE) begin
            prescale <= if_mem.w_data[PRESCALE_W-1:0];
        end
    end

    // mtime: a bus write to either half wins over the tick increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mtime <= '0;
        end else if (wr_vld && dec.sel == SEL_MTIME_LO) begin
            mtime[31:0] <= if_mem.w_data;
        end else if (wr_vld && dec.sel == SEL_MTIME_HI) begin
            mtime[63:32] <= if_mem.w_data;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Per-hart compare registers, written one 32-bit half at a time.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtimecmp[h] <= CLINT_MTIMECMP_RESET;
            end
        end else if (wr_vld) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (dec.hart == 4'(h)) begin
                    if (dec.sel == SEL_CMP_LO) mtimecmp[h][31:0]  <= if_mem.w_data;
                    if (dec.sel == SEL_CMP_HI) mtimecmp[h][63:32] <= if_mem.w_data;
                end
            end
        end
    end

    // Registered timer-interrupt compare against the pre-edge register values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mtip <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                o_mtip[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

`ifdef RISCV_CLINT_MSIP_EN
    logic [NUM_HARTS-1:0] msip_q;

    // Software-interrupt bits: bit 0 of each hart's word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            msip_q <= '0;
        end else if (wr_vld && dec.sel == SEL_MSIP) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (dec.hart == 4'(h)) msip_q[h] <= if_mem.w_data[0];
            end
        end
    end

    assign o_msip = msip_q;
`else
    assign o_msip = '0;
`endif

    // Read mux; the mtime high half comes from the shadow latched by the low read.
    always_comb begin
        rd_dat = '0;
        case (dec.sel)
`ifdef RISCV_CLINT_MSIP_EN
            SEL_MSIP: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (dec.hart == 4'(h)) rd_dat = {31'd0, msip_q[h]};
                end
            end
`endif
            SEL_CMP_LO: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (dec.hart == 4'(h)) rd_dat = mtimecmp[h][31:0];
                end
            end
            SEL_CMP_HI: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (dec.hart == 4'(h)) rd_dat = mtimecmp[h][63:32];
                end
            end
            SEL_PRESCALE: rd_dat[PRESCALE_W-1:0] = prescale;
            SEL_MTIME_LO: rd_dat = mtime[31:0];
            SEL_MTIME_HI: rd_dat = mtime_hi_shadow;
            default:      rd_dat = '0;
        endcase
    end

    // Register read data and capture the high half on a low-half read.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            if_mem.r_data   <= '0;
            mtime_hi_shadow <= '0;
        end else if (rd_vld) begin
            if_mem.r_data <= rd_dat;
            if (dec.sel == SEL_MTIME_LO) mtime_hi_shadow <= mtime[63:32];
        end
    end

endmodule

// File: tb/tb_riscv_clint.sv
// Self-checking bench for riscv_clint with two harts.
// Register-map vectors from a table; timing corner cases as hand-written sequences.
// Read expectations flow through a scoreboard queue.
module tb_riscv_clint;

    logic       i_clk;
    logic       i_rst;
    logic [1:0] o_mtip;
    logic [1:0] o_msip;
    logic [31:0] o_time;
    logic [31:0] o_timeh;

    mem_if mem ();

    riscv_clint #(
        .NUM_HARTS  (2),
        .PRESCALE_W (8)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .o_mtip  (o_mtip),
        .o_msip  (o_msip),
        .o_time  (o_time),
        .o_timeh (o_timeh),
        .if_mem  (mem)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge i_clk);
        mem.addr   = addr;
        mem.w_data = data;
        mem.w_en   = 1'b1;
        mem.valid  = 1'b1;
        @(posedge i_clk);
        #1;
        mem.valid  = 1'b0;
        mem.w_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        sb_t e;
        @(negedge i_clk);
        mem.addr  = addr;
        mem.w_en  = 1'b0;
        mem.valid = 1'b1;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        @(posedge i_clk);
        #1;
        mem.valid = 1'b0;
        e = sb_q.pop_front();
        check(e.name, {32'd0, mem.r_data}, {32'd0, e.exp});
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        logic [31:0] t0;
        logic        found;
        logic [1:0]  msip_exp;
        logic [31:0] msip_rd_exp;

`ifdef RISCV_CLINT_MSIP_EN
        msip_exp    = 2'b10;
        msip_rd_exp = 32'd1;
`else
        msip_exp    = 2'b00;
        msip_rd_exp = 32'd0;
`endif

        vecs[0]  = '{addr: 32'h4000, wr: 1'b0, wdata: 32'h0,      exp: 32'hFFFF_FFFF};
        vecs[1]  = '{addr: 32'h400C, wr: 1'b0, wdata: 32'h0,      exp: 32'hFFFF_FFFF};
        vecs[2]  = '{addr: 32'h4010, wr: 1'b0, wdata: 32'h0,      exp: 32'h0};
        vecs[3]  = '{addr: 32'hBFF0, wr: 1'b0, wdata: 32'h0,      exp: 32'h0};
        vecs[4]  = '{addr: 32'h0000, wr: 1'b0, wdata: 32'h0,      exp: 32'h0};
        vecs[5]  = '{addr: 32'h4008, wr: 1'b1, wdata: 32'h1234_5678, exp: 32'h0};
        vecs[6]  = '{addr: 32'h4008, wr: 1'b0, wdata: 32'h0,      exp: 32'h1234_5678};
        vecs[7]  = '{addr: 32'hBFF0, wr: 1'b1, wdata: 32'h1FF,    exp: 32'h0};
        vecs[8]  = '{addr: 32'hBFF0, wr: 1'b0, wdata: 32'h0,      exp: 32'hFF};
        vecs[9]  = '{addr: 32'h8000, wr: 1'b1, wdata: 32'hDEAD,   exp: 32'h0};
        vecs[10] = '{addr: 32'h8000, wr: 1'b0, wdata: 32'h0,      exp: 32'h0};
        vecs[11] = '{addr: 32'h4004, wr: 1'b0, wdata: 32'h0,      exp: 32'hFFFF_FFFF};

        mem.addr   = '0;
        mem.w_data = '0;
        mem.w_en   = 1'b0;
        mem.valid  = 1'b0;
        i_rst      = 1'b1;

        // Reset state
        #12;
        check("rst_time",   {32'd0, o_time},  64'd0);
        check("rst_timeh",  {32'd0, o_timeh}, 64'd0);
        check("rst_mtip",   {62'd0, o_mtip},  64'd0);
        check("rst_msip",   {62'd0, o_msip},  64'd0);
        check("rst_rdata",  {32'd0, mem.r_data}, 64'd0);
        check("ready_high", {63'd0, mem.ready}, 64'd1);

        // Free-running count at prescale 0
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        check("idle10_time", {32'd0, o_time}, 64'd10);
        check("idle10_mtip", {62'd0, o_mtip}, 64'd0);
        bus_read(32'h4004, 32'hFFFF_FFFF, "cmp0_hi_reset");

        // Register-map vectors
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            else            bus_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Prescale 3: one tick every 4 cycles after the write
        do_reset();
        bus_write(32'hBFF0, 32'd3);
        t0 = o_time;
        repeat (4) @(posedge i_clk);
        #1;
        check("presc_4cyc", {32'd0, o_time - t0}, 64'd1);
        repeat (8) @(posedge i_clk);
        #1;
        check("presc_12cyc", {32'd0, o_time - t0}, 64'd3);

        // Atomic read: high half comes from the shadow latched at the low read
        do_reset();
        bus_write(32'hBFF8, 32'hFFFF_FFFF);
        bus_write(32'hBFFC, 32'h0);
        bus_read(32'hBFF8, 32'hFFFF_FFFF, "shadow_lo");
        bus_read(32'hBFFC, 32'h0, "shadow_hi");
        check("live_hi_moved", {32'd0, o_timeh}, 64'd1);

        // Hart 1 compare at 0x20, hart 0 stays idle
        do_reset();
        bus_write(32'h400C, 32'h0);
        bus_write(32'h4008, 32'h20);
        bus_write(32'hBFF8, 32'h0);
        bus_write(32'hBFFC, 32'h0);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge i_clk);
            #1;
            if (o_time == 32'h20) found = 1'b1;
        end
        check("reach_0x20", {63'd0, found}, 64'd1);
        check("mtip_at_0x20", {62'd0, o_mtip}, 64'd0);
        @(posedge i_clk);
        #1;
        check("mtip_after_0x20", {62'd0, o_mtip}, 64'd2);

        // Wrap-around with mtimecmp[0] = 5
        do_reset();
        bus_write(32'h4004, 32'h0);
        bus_write(32'h4000, 32'h5);
        bus_write(32'hBFF8, 32'hFFFF_FFFF);
        bus_write(32'hBFFC, 32'hFFFF_FFFF);
        check("wrap_max", {o_timeh, o_time}, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_mtip_pre", {63'd0, o_mtip[0]}, 64'd1);
        @(posedge i_clk);
        #1;
        check("wrap_zero", {o_timeh, o_time}, 64'd0);
        check("wrap_mtip_hold", {63'd0, o_mtip[0]}, 64'd1);
        @(posedge i_clk);
        #1;
        check("wrap_mtip_fall", {63'd0, o_mtip[0]}, 64'd0);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(posedge i_clk);
            #1;
            if (o_time == 32'd5) found = 1'b1;
        end
        check("reach_5", {63'd0, found}, 64'd1);
        check("mtip_at_5", {63'd0, o_mtip[0]}, 64'd0);
        @(posedge i_clk);
        #1;
        check("mtip_after_5", {63'd0, o_mtip[0]}, 64'd1);

        // Software interrupt for hart 1
        bus_write(32'h0004, 32'h1);
        check("msip_out", {62'd0, o_msip}, {62'd0, msip_exp});
        bus_read(32'h0004, msip_rd_exp, "msip_rd");
        bus_read(32'h4000, 32'h5, "cmp0_lo");

        // Asynchronous reset in the middle of a cycle
        @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("arst_time",  {o_timeh, o_time}, 64'd0);
        check("arst_mtip",  {62'd0, o_mtip},   64'd0);
        check("arst_msip",  {62'd0, o_msip},   64'd0);
        check("arst_rdata", {32'd0, mem.r_data}, 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
